// File: rtl/lz4_stream_arbiter.sv
// Block-granular arbiter that lets two compressed LZ4 streams share one decompressor.
// A granted requester owns the decompressor from its reset pulse until the output drains quiet.
`timescale 1ns/1ps

module lz4_stream_arbiter #(
    parameter int word_size  = 8,
    parameter int DRAIN_IDLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [15:0]          len0,
    input  logic [15:0]          len1,
    input  logic                 in_valid0,
    input  logic                 in_valid1,
    input  logic [word_size-1:0] in_data0,
    input  logic [word_size-1:0] in_data1,
    output logic                 in_ready0,
    output logic                 in_ready1,
    output logic                 dec_reset,
    output logic                 dec_write,
    output logic [word_size-1:0] dec_compressed_word,
    input  logic [word_size-1:0] dec_uncompressed_word,
    input  logic                 dec_data_valid,
    output logic [word_size-1:0] out_word,
    output logic                 out_valid,
    output logic                 out_id,
    output logic [1:0]           grant,
    output logic                 busy,
    output logic                 block_done
);

    typedef enum logic [2:0] {IDLE, START, FEED, DRAIN, DONE} state_t;

    localparam logic [4:0] QUIET_LAST = 5'(DRAIN_IDLE - 1);

    state_t               state;
    logic                 last_id;
    logic                 cur_id;
    logic [15:0]          len_reg;
    logic [15:0]          byte_cnt;
    logic [4:0]           quiet_cnt;
    logic                 next_id;
    logic                 handshake;
    logic [word_size-1:0] cur_data;

    // On a tie the requester that was not served last wins.
    always_comb begin
        next_id = req1;
        if (req0 && req1) begin
            next_id = ~last_id;
        end
    end

    assign in_ready0  = (state == FEED) && !cur_id;
    assign in_ready1  = (state == FEED) && cur_id;
    assign handshake  = (in_valid0 && in_ready0) || (in_valid1 && in_ready1);
    assign cur_data   = cur_id ? in_data1 : in_data0;
    assign grant      = (state == IDLE) ? 2'b00 : (cur_id ? 2'b10 : 2'b01);
    assign busy       = (state != IDLE);
    assign block_done = (state == DONE);
    assign dec_reset  = reset || (state == START);

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            last_id             <= 1'b1;
            cur_id              <= 1'b0;
            len_reg             <= '0;
            byte_cnt            <= '0;
            quiet_cnt           <= '0;
            dec_write           <= 1'b0;
            dec_compressed_word <= '0;
            out_word            <= '0;
            out_valid           <= 1'b0;
            out_id              <= 1'b0;
        end else begin
            dec_write <= handshake;
            if (handshake) begin
                dec_compressed_word <= cur_data;
            end

            out_id <= cur_id;
            if (state == FEED || state == DRAIN) begin
                out_word  <= dec_uncompressed_word;
                out_valid <= dec_data_valid;
            end else begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        cur_id  <= next_id;
                        len_reg <= next_id ? len1 : len0;
                        state   <= START;
                    end
                end
                START: begin
                    byte_cnt  <= '0;
                    quiet_cnt <= '0;
                    state     <= (len_reg != 16'd0) ? FEED : DRAIN;
                end
                FEED: begin
                    if (handshake) begin
                        byte_cnt <= byte_cnt + 16'd1;
                        // Compare against len-1 so a 65535-byte block never wraps the counter.
                        if (byte_cnt == len_reg - 16'd1) begin
                            quiet_cnt <= '0;
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (dec_data_valid) begin
                        quiet_cnt <= '0;
                    end else if (quiet_cnt == QUIET_LAST) begin
                        quiet_cnt <= '0;
                        state     <= DONE;
                    end else begin
                        quiet_cnt <= quiet_cnt + 5'd1;
                    end
                end
                DONE: begin
                    last_id <= cur_id;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
